// File: rtl/wb_mem_bank.sv
// Weight/bias memory bank: z independent RAMs of depth cells, cleared by an
// init sweep after reset, then read (1-cycle registered, write-first) and
// written by the junction controller.
// Ports: clk/reset (async active-high); weA/w_addr/w_data per-memory write
// port; r_addr per-memory read address; r_data registered read data;
// r_valid marks r_data as a RUN-issued read; busy high while init owns the RAMs.
module wb_mem_bank #(
    parameter int                p        = 64,
    parameter int                fo       = 8,
    parameter int                z        = 32,
    parameter int                width    = 16,
    parameter int                depth    = p * fo / z,
    parameter logic [width-1:0]  init_val = '0,
    localparam int               AW       = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [z-1:0]         weA,
    input  logic [AW-1:0]        r_addr [z-1:0],
    input  logic [AW-1:0]        w_addr [z-1:0],
    input  logic [width-1:0]     w_data [z-1:0],
    output logic [width-1:0]     r_data [z-1:0],
    output logic                 r_valid,
    output logic                 busy
);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_CELL = AW'(depth - 1);
    // One extra bit so depth itself is representable for the range check.
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(depth);

    // Addresses can exceed depth only when depth is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            r_valid_q, r_valid_d;
    logic            init_mode;
    logic            run_mode;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // The edge that writes the last cell also moves to RUN, so INIT lasts
    // exactly depth cycles after reset release.
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && init_cnt_q == LAST_CELL) begin
            state_d = S_RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        init_mode = (state_q == S_INIT);
        run_mode  = (state_q == S_RUN);
        busy      = init_mode;
    end

    // ---------------- init counter ----------------
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (init_mode) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end

    // A read sampled in RUN is presented on the following cycle, so valid
    // trails the first RUN cycle by one.
    assign r_valid_d = run_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= r_valid_d;
        end
    end

    assign r_valid = r_valid_q;

    // ---------------- per-memory storage ----------------
    for (genvar g = 0; g < z; g++) begin : g_mem
        logic [width-1:0] mem_q [depth];
        logic             we;
        logic [AW-1:0]    wa;
        logic [width-1:0] wd;
        logic [width-1:0] rd_d;
        logic [width-1:0] rd_q;

        // Init sweep takes the write port; controller writes are locked out.
        always_comb begin
            we = 1'b0;
            wa = w_addr[g];
            wd = w_data[g];
            if (init_mode) begin
                we = 1'b1;
                wa = init_cnt_q;
                wd = init_val;
            end else if (weA[g] && addr_ok(w_addr[g])) begin
                we = 1'b1;
            end
        end

        // No reset on the array itself; gating on reset drops any write
        // that coincides with an asserted reset.
        always_ff @(posedge clk) begin
            if (we && !reset) begin
                mem_q[wa] <= wd;
            end
        end

        // Write-first: a same-address write on the same edge is forwarded.
        always_comb begin
            rd_d = '0;
            if (run_mode && addr_ok(r_addr[g])) begin
                if (weA[g] && (w_addr[g] == r_addr[g])) begin
                    rd_d = w_data[g];
                end else begin
                    rd_d = mem_q[r_addr[g]];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign r_data[g] = rd_q;
    end

endmodule

// File: doc/wb_mem_bank.md
Name: wb_mem_bank

Overview:
- Responder side of the weight/bias memory controller interface.
- Holds z independent weight memories, each with p*fo/z cells, in a single bank.
- Consumes the controller's per-memory read addresses, write addresses and write enables. Returns registered read data to the datapath and accepts updated weights written back.
- After reset, an internal init sequencer clears every cell. The bank then enters normal operation.

Parameters:
- p, 64, neurons in the layer feeding the junction.
- fo, 8, fan-out per neuron.
- z, 32, degree of parallelism; number of weight memories.
- width, 16, bits per weight/bias word.
- depth, p*fo/z, cells per memory (derived; 16 at defaults).
- init_val, 0, value written into every cell during initialization.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high; clears outputs and restarts init.
- weA, input, z, per-memory write enable from the controller.
- r_addr, input, z x $clog2(depth), per-memory read address (unpacked array [z-1:0]).
- w_addr, input, z x $clog2(depth), per-memory write address (unpacked array [z-1:0]).
- w_data, input, z x width, per-memory write data (unpacked array [z-1:0]).
- r_data, output, z x width, per-memory registered read data (unpacked array [z-1:0]).
- r_valid, output, 1, high when r_data reflects a read issued in the previous cycle in RUN.
- busy, output, 1, high while the init sequencer owns the memories.

Behaviour:
- Reset (async, active-high):
  - r_data for all z memories goes to 0; r_valid goes to 0; busy goes to 1.
  - The FSM is forced to INIT and the init counter goes to 0.
  - Memory contents are not cleared by reset itself.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle, writes init_val to cell init_cnt of all z memories in parallel, then increments init_cnt.
  - After init_cnt = depth-1 is written, moves to RUN on the next edge. INIT therefore lasts exactly depth cycles after reset deassertion.
  - busy stays 1 throughout INIT and drops to 0 on the edge that enters RUN.
  - In INIT, weA/w_addr/w_data are ignored, r_data holds 0 and r_valid holds 0.
- RUN:
  - Read latency is 1 cycle: r_data[i] at edge n+1 equals mem[i][r_addr[i]] sampled at edge n.
  - r_valid = 1 every cycle from the second RUN cycle onward.
  - Write: when weA[i]=1 at an edge, mem[i][w_addr[i]] <= w_data[i]. Memories are independent; any subset of weA may be set.
  - Read-during-write, same memory and same address, same edge: r_data[i] returns the new w_data[i] (write-first forwarding).
  - Read-during-write, different addresses: r_data[i] returns the old contents of r_addr[i]; no interaction.
  - Out-of-range addresses (>= depth, only possible when depth is not a power of 2): writes are dropped and reads return 0.
- Reset mid-operation:
  - Reset during INIT or RUN restarts INIT from cell 0 and discards any write in flight.
  - After release, all cells read init_val after depth cycles.
- Width rules:
  - Address width is $clog2(depth), with a minimum of 1.
  - Data passes through unmodified; no arithmetic on stored words.
- RTL and timing:
  - No combinational path from any input to r_data, r_valid or busy.
  - Implemented as z separate arrays so synthesis can map each memory to its own block/distributed RAM.

Test Plan:
- Init sweep: defaults, release reset at t0 -> busy=1 for exactly 16 cycles then 0; afterwards reading r_addr=0..15 on all 32 memories returns 0; r_valid asserts from the second RUN cycle.
- Write/read per memory: in RUN, weA=32'h0000_0001, w_addr[0]=5, w_data[0]=16'hBEEF; next cycle r_addr[0]=5 -> r_data[0]=16'hBEEF one cycle later; memories 1..31 at address 5 still read 0.
- Parallel writes: weA=all ones, w_addr[i]=i%16, w_data[i]=i+1 -> subsequent reads of memory i at address i%16 return i+1 for all 32 memories.
- Write-first forwarding: weA[3]=1, w_addr[3]=r_addr[3]=7, w_data[3]=16'h1234 on the same edge -> r_data[3]=16'h1234 next cycle. Same test with r_addr[3]=6 -> old value returned.
- Init lockout: during INIT, drive weA=all ones, w_data=16'hFFFF -> after INIT every cell still reads 0; r_data stays 0 throughout INIT.
- Mid-run reset: write 16'hAAAA to memory 10 address 2, pulse reset for 3 cycles asynchronously (off the clock edge) -> r_data and r_valid are 0 immediately; busy=1; after 16 cycles, memory 10 address 2 reads 0.
